// File: rtl/tm_output_accumulator_pkg.sv
// Shared definitions for the output accumulator: default widths, FSM encoding
// and the post-accumulation ReLU / saturation helpers.
package tm_output_accumulator_pkg;

    localparam int DEF_TM            = 32'd16;
    localparam int DEF_FEATURE_WIDTH = 32'd16;
    localparam int DEF_ACC_WIDTH     = 32'd24;
    localparam int DEF_PIX_DEPTH     = 32'd64;
    localparam int DEF_PIX_AW        = 32'd6;
    localparam int DEF_CH_AW         = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } acc_state_t;

    localparam logic signed [DEF_ACC_WIDTH-1:0] SAT_MAX =
        {{(DEF_ACC_WIDTH-DEF_FEATURE_WIDTH+1){1'b0}}, {(DEF_FEATURE_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_ACC_WIDTH-1:0] SAT_MIN =
        {{(DEF_ACC_WIDTH-DEF_FEATURE_WIDTH+1){1'b1}}, {(DEF_FEATURE_WIDTH-1){1'b0}}};

    function automatic logic signed [DEF_FEATURE_WIDTH-1:0] sat_trunc(
        input logic signed [DEF_ACC_WIDTH-1:0] v
    );
        logic signed [DEF_FEATURE_WIDTH-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DEF_FEATURE_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DEF_FEATURE_WIDTH-1:0];
        end else begin
            r = v[DEF_FEATURE_WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [DEF_ACC_WIDTH-1:0] relu(
        input logic signed [DEF_ACC_WIDTH-1:0] v,
        input logic                            en
    );
        logic signed [DEF_ACC_WIDTH-1:0] r;
        if (en && v[DEF_ACC_WIDTH-1]) begin
            r = {DEF_ACC_WIDTH{1'b0}};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/tm_output_accumulator_acc_bank.sv
// One output-channel lane of accumulator storage: simple dual-port RAM with a
// registered read that returns the old word on a same-address write.
module acc_bank
    import tm_output_accumulator_pkg::*;
#(
    parameter int DEPTH = DEF_PIX_DEPTH,
    parameter int AW    = DEF_PIX_AW,
    parameter int DW    = DEF_ACC_WIDTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage write and registered read
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/tm_output_accumulator.sv
// Accumulates signed per-channel partial sums over the input-channel groups of a
// tile, then streams ReLU'd, saturated Tm-lane pixels under valid/ready.
module tm_output_accumulator
    import tm_output_accumulator_pkg::*;
#(
    parameter int Tm            = DEF_TM,
    parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int PIX_DEPTH     = DEF_PIX_DEPTH,
    parameter int PIX_AW        = DEF_PIX_AW,
    parameter int CH_AW         = DEF_CH_AW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic [7:0]                  cfg_num_groups,
    input  logic [PIX_AW:0]             cfg_num_pix,
    input  logic                        cfg_relu_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CH_AW-1:0]            in_channel,
    input  logic [PIX_AW-1:0]           in_pix,
    input  logic [FEATURE_WIDTH-1:0]    in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PIX_AW-1:0]           out_addr,
    output logic [Tm*FEATURE_WIDTH-1:0] out_data,
    output logic                        busy,
    output logic                        done,
    output logic                        ovf_sticky
);

    localparam int LANE_W = (Tm > 32'd1) ? $clog2(Tm) : 32'd1;
    localparam logic [CH_AW:0]    TM_LIMIT = (CH_AW+1)'(Tm);
    localparam logic [PIX_AW:0]   PIX_MAX  = (PIX_AW+1)'(PIX_DEPTH);
    localparam logic [PIX_AW:0]   NPIX_ONE = {{PIX_AW{1'b0}}, 1'b1};
    localparam logic [PIX_AW-1:0] PIX_ONE  = {{(PIX_AW-1){1'b0}}, 1'b1};

    acc_state_t                  state_r, state_next_s;
    logic [7:0]                  num_groups_r, group_cnt_r;
    logic [PIX_AW:0]             num_pix_r;
    logic                        relu_en_r, flush_cnt_r, rd_pend_r, rd_next_s;
    logic [PIX_AW-1:0]           pix_r, rd_addr_s;
    logic                        in_ready_r, out_valid_r, busy_r, done_r, ovf_r;
    logic [PIX_AW-1:0]           out_addr_r;
    logic [Tm*FEATURE_WIDTH-1:0] out_data_r, packed_s;
    logic                        accept_s, group_done_s, out_hs_s, last_pix_s;

    logic                        s1_valid_r;
    logic [LANE_W-1:0]           s1_lane_r;
    logic [PIX_AW-1:0]           s1_pix_r;
    logic [FEATURE_WIDTH-1:0]    s1_data_r;
    logic                        fwd_valid_r;
    logic [LANE_W-1:0]           fwd_lane_r;
    logic [PIX_AW-1:0]           fwd_pix_r;
    logic [ACC_WIDTH-1:0]        fwd_data_r;
    logic [ACC_WIDTH-1:0]        sext_s, operand_s, sum_s;
    logic                        fwd_hit_s, seen_s, ovf_s;

    // One bit per cell: set once the cell has been written in this tile
    logic [PIX_DEPTH-1:0]        touched_r [Tm];
    logic [ACC_WIDTH-1:0]        bank_rdata_s [Tm];

    assign accept_s     = in_valid && in_ready_r;
    assign group_done_s = (group_cnt_r + 8'd1) == num_groups_r;
    assign out_hs_s     = out_valid_r && out_ready;
    assign last_pix_s   = ({1'b0, pix_r} == (num_pix_r - NPIX_ONE));

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_addr   = out_addr_r;
    assign out_data   = out_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign ovf_sticky = ovf_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) state_next_s = ST_ACCUM;
                else           state_next_s = ST_IDLE;
            end
            ST_ACCUM: begin
                if (accept_s && in_last && group_done_s) state_next_s = ST_FLUSH;
                else                                     state_next_s = ST_ACCUM;
            end
            ST_FLUSH: begin
                if (flush_cnt_r) state_next_s = ST_DRAIN;
                else             state_next_s = ST_FLUSH;
            end
            ST_DRAIN: begin
                if (out_hs_s && last_pix_s) state_next_s = ST_IDLE;
                else                        state_next_s = ST_DRAIN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Bank read address: sample pixel while accumulating, pixel 0 on the last
    // flush cycle, otherwise the pixel after the one being presented
    always_comb begin
        rd_addr_s = pix_r + PIX_ONE;
        rd_next_s = 1'b0;
        case (state_r)
            ST_ACCUM: rd_addr_s = in_pix;
            ST_FLUSH: begin
                rd_addr_s = {PIX_AW{1'b0}};
                rd_next_s = flush_cnt_r;
            end
            ST_DRAIN: begin
                rd_addr_s = pix_r + PIX_ONE;
                rd_next_s = out_hs_s && !last_pix_s;
            end
            default: rd_addr_s = pix_r + PIX_ONE;
        endcase
    end

    // Tile configuration, counters and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            num_groups_r <= 8'd1;
            group_cnt_r  <= 8'd0;
            num_pix_r    <= NPIX_ONE;
            relu_en_r    <= 1'b0;
            flush_cnt_r  <= 1'b0;
            pix_r        <= {PIX_AW{1'b0}};
            rd_pend_r    <= 1'b0;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_addr_r   <= {PIX_AW{1'b0}};
            out_data_r   <= {(Tm*FEATURE_WIDTH){1'b0}};
        end else begin
            rd_pend_r  <= rd_next_s;
            in_ready_r <= (state_next_s == ST_ACCUM);
            busy_r     <= (state_next_s != ST_IDLE);
            done_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        group_cnt_r <= 8'd0;
                        relu_en_r   <= cfg_relu_en;
                        if (cfg_num_groups == 8'd0) num_groups_r <= 8'd1;
                        else                        num_groups_r <= cfg_num_groups;
                        if (cfg_num_pix == {(PIX_AW+1){1'b0}}) num_pix_r <= NPIX_ONE;
                        else if (cfg_num_pix > PIX_MAX)         num_pix_r <= PIX_MAX;
                        else                                    num_pix_r <= cfg_num_pix;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s && in_last) group_cnt_r <= group_cnt_r + 8'd1;
                end
                ST_FLUSH: begin
                    flush_cnt_r <= ~flush_cnt_r;
                    pix_r       <= {PIX_AW{1'b0}};
                end
                ST_DRAIN: begin
                    if (rd_pend_r) begin
                        out_valid_r <= 1'b1;
                        out_addr_r  <= pix_r;
                        out_data_r  <= packed_s;
                    end else if (out_hs_s) begin
                        out_valid_r <= 1'b0;
                        if (last_pix_s) done_r <= 1'b1;
                        else            pix_r  <= pix_r + PIX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-modify-write pipeline: stage 1 captures the sample, stage 2 keeps
    // its own result for forwarding into an immediately following same-cell hit
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_lane_r   <= {LANE_W{1'b0}};
            s1_pix_r    <= {PIX_AW{1'b0}};
            s1_data_r   <= {FEATURE_WIDTH{1'b0}};
            fwd_valid_r <= 1'b0;
            fwd_lane_r  <= {LANE_W{1'b0}};
            fwd_pix_r   <= {PIX_AW{1'b0}};
            fwd_data_r  <= {ACC_WIDTH{1'b0}};
        end else begin
            s1_valid_r  <= accept_s && ({1'b0, in_channel} < TM_LIMIT);
            s1_lane_r   <= in_channel[LANE_W-1:0];
            s1_pix_r    <= in_pix;
            s1_data_r   <= in_data;
            fwd_valid_r <= s1_valid_r;
            fwd_lane_r  <= s1_lane_r;
            fwd_pix_r   <= s1_pix_r;
            fwd_data_r  <= sum_s;
        end
    end

    // Stage 2 sum: a cell not yet written in this tile starts from the sample
    always_comb begin
        sext_s    = {{(ACC_WIDTH-FEATURE_WIDTH){s1_data_r[FEATURE_WIDTH-1]}}, s1_data_r};
        fwd_hit_s = fwd_valid_r && (fwd_lane_r == s1_lane_r) && (fwd_pix_r == s1_pix_r);
        seen_s    = touched_r[s1_lane_r][s1_pix_r];
        if (fwd_hit_s) operand_s = fwd_data_r;
        else           operand_s = bank_rdata_s[s1_lane_r];
        if (seen_s) sum_s = operand_s + sext_s;
        else        sum_s = sext_s;
        ovf_s = s1_valid_r && seen_s
                && (operand_s[ACC_WIDTH-1] == sext_s[ACC_WIDTH-1])
                && (sum_s[ACC_WIDTH-1] != operand_s[ACC_WIDTH-1]);
    end

    // Written-cell map and overflow flag, both cleared at tile start
    always_ff @(posedge clk) begin
        if (rst || ((state_r == ST_IDLE) && cfg_start)) begin
            for (int i = 0; i < Tm; i++) touched_r[i] <= {PIX_DEPTH{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            if (s1_valid_r) touched_r[s1_lane_r][s1_pix_r] <= 1'b1;
            if (ovf_s)      ovf_r <= 1'b1;
        end
    end

    for (genvar g = 0; g < Tm; g++) begin : g_lane
        logic                            hit_r;
        logic signed [ACC_WIDTH-1:0]     lane_sum_s;
        logic signed [FEATURE_WIDTH-1:0] lane_out_s;

        acc_bank #(
            .DEPTH (PIX_DEPTH),
            .AW    (PIX_AW),
            .DW    (ACC_WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (s1_valid_r && (s1_lane_r == LANE_W'(g))),
            .waddr (s1_pix_r),
            .wdata (sum_s),
            .raddr (rd_addr_s),
            .rdata (bank_rdata_s[g])
        );

        // Written flag read alongside the bank word
        always_ff @(posedge clk) begin
            hit_r <= touched_r[g][rd_addr_s];
        end

        // Lane post-processing: unwritten cells read as zero
        always_comb begin
            if (hit_r) lane_sum_s = bank_rdata_s[g];
            else       lane_sum_s = {ACC_WIDTH{1'b0}};
            lane_out_s = sat_trunc(relu(lane_sum_s, relu_en_r));
        end

        assign packed_s[g*FEATURE_WIDTH +: FEATURE_WIDTH] = lane_out_s;
    end

endmodule
